// File: rtl/gray_count_rx.sv
// rtl/gray_count_rx.sv - Gray-coded bus receiver: synchronize, stability-filter, decode, classify steps
//
// Purpose:
//   Samples an asynchronous WIDTH-bit Gray bus, passes it through a two-flop
//   synchronizer, and accepts a new code only after it has been seen for
//   STABLE consecutive synchronized samples. Each accepted code is decoded to
//   binary and classified against the previous accepted code as an up step,
//   down step (with wrap detection) or an illegal multi-bit jump.
//
// Optional feature (macro GRAY_RX_ERRCNT_EN):
//   defined     - err_cnt_o is a saturating 8-bit count of ERR events, cleared by clr_i
//   not defined - err_cnt_o is tied to 0 and clr_i is ignored
//
// Ports:
//   clk_i      in   1      system clock, rising edge
//   rst_ni     in   1      asynchronous active-low reset
//   gray_i     in   WIDTH  asynchronous Gray-coded input
//   clr_i      in   1      synchronous clear of err_cnt_o
//   bin_o      out  WIDTH  binary value of the last accepted code
//   valid_o    out  1      one-cycle pulse per accepted code
//   up_o       out  1      accepted code is previous + 1 (qualifies valid_o)
//   down_o     out  1      accepted code is previous - 1 (qualifies valid_o)
//   wrap_o     out  1      up/down step crossed max <-> 0 (qualifies valid_o)
//   err_o      out  1      Gray distance to previous code > 1 (qualifies valid_o)
//   err_cnt_o  out  8      saturating ERR event count
//   locked_o   out  1      a reference code has been acquired

module gray_count_rx #(
    parameter int WIDTH  = 10,
    parameter int STABLE = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] gray_i,
    input  logic             clr_i,
    output logic [WIDTH-1:0] bin_o,
    output logic             valid_o,
    output logic             up_o,
    output logic             down_o,
    output logic             wrap_o,
    output logic             err_o,
    output logic [7:0]       err_cnt_o,
    output logic             locked_o
);

    // Counter must hold 0..STABLE-1; keep at least one bit when STABLE == 1.
    localparam int               CNT_W   = (STABLE > 1) ? $clog2(STABLE) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE - 1);
    localparam logic [WIDTH-1:0] BIN_MAX = {WIDTH{1'b1}};

    typedef enum logic [0:0] {
        ST_ACQUIRE = 1'b0,
        ST_TRACK   = 1'b1
    } state_e;

    function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    state_e           state_q, state_d;
    logic [WIDTH-1:0] s1_q, s2_q;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] bin_q, bin_d;
    logic             valid_q, valid_d;
    logic             up_q, up_d;
    logic             down_q, down_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;
    logic             locked_q, locked_d;

    logic             accept;
    logic [WIDTH-1:0] new_bin;
    logic [WIDTH-1:0] bin_inc;
    logic [WIDTH-1:0] diff;
    logic             single_bit;

    assign new_bin = gray2bin(cand_q);
    assign bin_inc = bin_q + WIDTH'(1);
    assign diff    = cand_q ^ acc_q;
    // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
    assign single_bit = (diff != '0) && ((diff & (diff - WIDTH'(1))) == '0);

    // In ACQUIRE the first stable code is taken even if it equals the reset
    // value of acc, so a bus held at 0 through reset still gets acquired.
    assign accept = (s2_q == cand_q) && (cnt_q == CNT_MAX) &&
                    ((cand_q != acc_q) || (state_q == ST_ACQUIRE));

    // Stability filter
    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        if (s2_q != cand_q) begin
            cand_d = s2_q;
            cnt_d  = '0;
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // State machine and registered outputs
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        bin_d    = bin_q;
        locked_d = locked_q;
        valid_d  = 1'b0;
        up_d     = 1'b0;
        down_d   = 1'b0;
        wrap_d   = 1'b0;
        err_d    = 1'b0;

        unique case (state_q)
            ST_ACQUIRE: begin
                if (accept) begin
                    acc_d    = cand_q;
                    bin_d    = new_bin;
                    valid_d  = 1'b1;
                    locked_d = 1'b1;
                    state_d  = ST_TRACK;
                end
            end
            ST_TRACK: begin
                if (accept) begin
                    // The new code is always taken as reference, even after an
                    // illegal jump, so tracking resyncs rather than sticking.
                    acc_d   = cand_q;
                    bin_d   = new_bin;
                    valid_d = 1'b1;
                    if (single_bit) begin
                        if (new_bin == bin_inc) begin
                            up_d   = 1'b1;
                            wrap_d = (new_bin == '0);
                        end else begin
                            down_d = 1'b1;
                            wrap_d = (new_bin == BIN_MAX);
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_ACQUIRE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_ACQUIRE;
            s1_q     <= '0;
            s2_q     <= '0;
            cand_q   <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            bin_q    <= '0;
            valid_q  <= 1'b0;
            up_q     <= 1'b0;
            down_q   <= 1'b0;
            wrap_q   <= 1'b0;
            err_q    <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            s1_q     <= gray_i;
            s2_q     <= s1_q;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            bin_q    <= bin_d;
            valid_q  <= valid_d;
            up_q     <= up_d;
            down_q   <= down_d;
            wrap_q   <= wrap_d;
            err_q    <= err_d;
            locked_q <= locked_d;
        end
    end

`ifdef GRAY_RX_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    // Clear has priority over a coincident error; the ERR pulse itself is unaffected.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clr_i) begin
            err_cnt_d = '0;
        end else if (err_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt_o = err_cnt_q;
`else
    logic unused_clr;
    assign unused_clr = clr_i;
    assign err_cnt_o  = 8'd0;
`endif

    assign bin_o    = bin_q;
    assign valid_o  = valid_q;
    assign up_o     = up_q;
    assign down_o   = down_q;
    assign wrap_o   = wrap_q;
    assign err_o    = err_q;
    assign locked_o = locked_q;

endmodule

// File: tb/tb_gray_count_rx.sv
// tb/tb_gray_count_rx.sv - directed self-checking bench for gray_count_rx

module tb_gray_count_rx;

`ifdef GRAY_RX_ERRCNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk_i;
    logic       rst_ni;
    logic [9:0] gray_i;
    logic       clr_i;
    logic [9:0] bin_o;
    logic       valid_o;
    logic       up_o;
    logic       down_o;
    logic       wrap_o;
    logic       err_o;
    logic [7:0] err_cnt_o;
    logic       locked_o;

    int checks   = 0;
    int failures = 0;

    gray_count_rx #(.WIDTH(10), .STABLE(4)) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .gray_i    (gray_i),
        .clr_i     (clr_i),
        .bin_o     (bin_o),
        .valid_o   (valid_o),
        .up_o      (up_o),
        .down_o    (down_o),
        .wrap_o    (wrap_o),
        .err_o     (err_o),
        .err_cnt_o (err_cnt_o),
        .locked_o  (locked_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic logic [7:0] ecnt(input int v);
        return CNT_EN ? 8'(v) : 8'd0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // Drive code (or keep it) and expect exactly one VALID at edge 7 after the change.
    task automatic expect_accept(input string tag, input logic [9:0] code,
                                 input logic [9:0] exp_bin, input logic eu, input logic ed,
                                 input logic ew, input logic ee, input logic [7:0] exp_cnt,
                                 input bit clr_at);
        gray_i = code;
        step(6);
        chk({tag, ".early_valid"}, {31'd0, valid_o}, 32'd0);
        if (clr_at) clr_i = 1'b1;
        step(1);
        clr_i = 1'b0;
        chk({tag, ".valid"},   {31'd0, valid_o},  32'd1);
        chk({tag, ".bin"},     {22'd0, bin_o},    {22'd0, exp_bin});
        chk({tag, ".up"},      {31'd0, up_o},     {31'd0, eu});
        chk({tag, ".down"},    {31'd0, down_o},   {31'd0, ed});
        chk({tag, ".wrap"},    {31'd0, wrap_o},   {31'd0, ew});
        chk({tag, ".err"},     {31'd0, err_o},    {31'd0, ee});
        chk({tag, ".locked"},  {31'd0, locked_o}, 32'd1);
        chk({tag, ".err_cnt"}, {24'd0, err_cnt_o}, {24'd0, exp_cnt});
        step(1);
        chk({tag, ".pulse_end"}, {31'd0, valid_o}, 32'd0);
    endtask

    initial begin
        int seen;
        rst_ni = 1'b0;
        gray_i = 10'h007;
        clr_i  = 1'b0;

        // Reset state
        step(3);
        chk("rst.bin",     {22'd0, bin_o},     32'd0);
        chk("rst.valid",   {31'd0, valid_o},   32'd0);
        chk("rst.locked",  {31'd0, locked_o},  32'd0);
        chk("rst.err_cnt", {24'd0, err_cnt_o}, 32'd0);
        chk("rst.flags",   {28'd0, up_o, down_o, wrap_o, err_o}, 32'd0);

        // Acquire nonzero code held through reset: BIN=5 at edge 7 after release
        rst_ni = 1'b1;
        expect_accept("acquire", 10'h007, 10'd5, 1'b0, 1'b0, 1'b0, 1'b0, ecnt(0), 1'b0);

        // Up step 0x007 -> 0x005 : 5 -> 6
        expect_accept("up", 10'h005, 10'd6, 1'b1, 1'b0, 1'b0, 1'b0, ecnt(0), 1'b0);

        // Glitch 0x004 for STABLE-1 cycles, then restore: nothing accepted
        gray_i = 10'h004;
        step(3);
        gray_i = 10'h005;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            step(1);
            if (valid_o) seen++;
        end
        chk("glitch.no_valid", 32'(seen), 32'd0);
        chk("glitch.bin", {22'd0, bin_o}, 32'd6);

        // Down step 0x005 -> 0x007 : 6 -> 5
        expect_accept("down", 10'h007, 10'd5, 1'b0, 1'b1, 1'b0, 1'b0, ecnt(0), 1'b0);

        // Illegal jump 0x007 -> 0x000
        expect_accept("jump", 10'h000, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, ecnt(1), 1'b0);

        // Wrap down 0 -> 1023, then wrap up 1023 -> 0
        expect_accept("wrap_dn", 10'h200, 10'd1023, 1'b0, 1'b1, 1'b1, 1'b0, ecnt(1), 1'b0);
        expect_accept("wrap_up", 10'h000, 10'd0, 1'b1, 1'b0, 1'b1, 1'b0, ecnt(1), 1'b0);

        // 254 more illegal jumps bring the count to 255
        for (int i = 0; i < 254; i++) begin
            gray_i = (i % 2 == 0) ? 10'h007 : 10'h000;
            step(8);
        end
        chk("sat.reach", {24'd0, err_cnt_o}, {24'd0, ecnt(255)});

        // One more jump must saturate, not wrap
        expect_accept("sat", 10'h007, 10'd5, 1'b0, 1'b0, 1'b0, 1'b1, ecnt(255), 1'b0);

        // CLR coincident with ERR: CLR wins, ERR pulse still issued
        expect_accept("clr_err", 10'h000, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, ecnt(0), 1'b1);
        expect_accept("after_clr", 10'h007, 10'd5, 1'b0, 1'b0, 1'b0, 1'b1, ecnt(1), 1'b0);

        // Reset mid-filter: change pending with cnt=2, then async reset
        gray_i = 10'h005;
        step(5);
        rst_ni = 1'b0;
        #1;
        chk("midrst.bin",    {22'd0, bin_o},     32'd0);
        chk("midrst.locked", {31'd0, locked_o},  32'd0);
        chk("midrst.cnt",    {24'd0, err_cnt_o}, 32'd0);
        chk("midrst.valid",  {31'd0, valid_o},   32'd0);
        step(2);
        rst_ni = 1'b1;
        expect_accept("reacq", 10'h005, 10'd6, 1'b0, 1'b0, 1'b0, 1'b0, ecnt(0), 1'b0);

        // Constant 0 through reset: acquisition at edge STABLE after release
        rst_ni = 1'b0;
        gray_i = 10'h000;
        step(2);
        rst_ni = 1'b1;
        step(3);
        chk("acq0.early", {31'd0, valid_o}, 32'd0);
        step(1);
        chk("acq0.valid",  {31'd0, valid_o},  32'd1);
        chk("acq0.bin",    {22'd0, bin_o},    32'd0);
        chk("acq0.locked", {31'd0, locked_o}, 32'd1);
        chk("acq0.flags",  {28'd0, up_o, down_o, wrap_o, err_o}, 32'd0);
        step(1);
        chk("acq0.pulse_end", {31'd0, valid_o}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gray_count_rx.md
# gray_count_rx

Receive-side companion to the board's Gray-coded counter output. Samples a WIDTH-bit Gray bus from an asynchronous source (another board's Gray LED header, or an absolute encoder), synchronizes and stability-filters it, and decodes it to binary. Classifies every accepted change as an up step, down step or illegal multi-bit jump, and reports wrap-around and error statistics to downstream logic (LED/display drivers, activity indicators).

## Interface
- WIDTH, 10: Gray/binary bus width (≥2)
- STABLE, 4: consecutive synchronized samples required before a new code is accepted (≥1)
- CLK  in  1: system clock, all logic on rising edge
- RST_N  in  1: asynchronous, active-low reset
- GRAY_IN  in  WIDTH: asynchronous Gray-coded input
- CLR  in  1: synchronous clear of ERR_CNT
- BIN  out  WIDTH: binary value of the last accepted code
- VALID  out  1: one-cycle pulse when a new code is accepted
- UP  out  1: qualifies VALID, accepted code is previous binary +1 (mod 2^WIDTH)
- DOWN  out  1: qualifies VALID, accepted code is previous binary −1 (mod 2^WIDTH)
- WRAP  out  1: qualifies VALID, the UP/DOWN step crossed max↔0
- ERR  out  1: qualifies VALID, Gray Hamming distance to previous code >1
- ERR_CNT  out  8: saturating count of ERR events
- LOCKED  out  1: a reference code has been acquired

## Operation
- Sync: two flops s1→s2 per bit, both reset to 0.
- Filter: registers cand (WIDTH) and cnt (0..STABLE−1, saturating). s2≠cand: cand←s2, cnt←0. Else cnt increments until STABLE−1.
- Accept condition: s2==cand && cnt==STABLE−1 && (cand≠acc || state==ACQUIRE).
- States: ACQUIRE (reset), TRACK.
  - ACQUIRE, on accept: acc←cand, BIN←decode(cand), VALID=1, UP=DOWN=WRAP=ERR=0, LOCKED←1, go TRACK.
  - TRACK, on accept: compute d = popcount(cand ^ acc). d==1: UP or DOWN from binary comparison; WRAP=1 on 2^WIDTH−1→0 (UP) or 0→2^WIDTH−1 (DOWN). d>1: ERR=1, UP=DOWN=WRAP=0, ERR_CNT increments. acc and BIN always take the new code (resync, no rejection).
  - No path back to ACQUIRE except reset.
- Decode: bin[W−1]=g[W−1]; bin[i]=bin[i+1]^g[i].
- UP, DOWN, WRAP, ERR are zero whenever VALID is 0; UP and DOWN are mutually exclusive.
- ERR_CNT saturates at 255. CLR and ERR in the same cycle: CLR wins (ERR_CNT←0), ERR pulse still issued.
- Reset mid-filter discards cand/cnt; the next acquired code is taken as reference without a step check.

## Timing
- Reset values: BIN=0, VALID=UP=DOWN=WRAP=ERR=0, ERR_CNT=0, LOCKED=0, s1=s2=cand=acc=0, cnt=0, state ACQUIRE.
- Input change set up before edge 1 and held: s2 updates at edge 2, cand at edge 3, accept (BIN/VALID/qualifiers registered) at edge 3+STABLE (7 with default).
- Input change shorter than STABLE+... i.e. reverting before cnt reaches STABLE−1: no accept, no VALID.
- After reset with constant GRAY_IN=0: acquisition at edge STABLE after reset release; otherwise at edge 3+STABLE.
- All outputs registered; VALID is exactly one cycle per accepted code; back-to-back accepts need ≥STABLE+1 cycles between input changes.

## Configuration
- GRAY_RX_ERRCNT_EN defined: ERR_CNT counter and CLR logic present as above.
- Not defined: ERR_CNT is constant 0, CLR ignored; ERR pulse, UP/DOWN/WRAP behaviour unchanged.

## Test plan
- Acquire: reset, GRAY_IN=0x007 held -> VALID pulse with BIN=5, LOCKED=1, UP=DOWN=ERR=0, at edge 3+STABLE.
- Up step: from 0x007 drive 0x005 -> VALID, BIN=6, UP=1, WRAP=0, ERR_CNT unchanged.
- Wrap both ways: 0x200 (1023) -> 0x000 gives UP=1, WRAP=1, BIN=0; then 0x000 -> 0x200 gives DOWN=1, WRAP=1, BIN=1023.
- Illegal jump: from 0x007 drive 0x000 -> VALID, ERR=1, BIN=0, ERR_CNT=1; 256 such jumps leave ERR_CNT=255; CLR coincident with ERR -> ERR_CNT=0.
- Glitch: while locked at 0x005, pulse 0x004 for STABLE−1 cycles then restore -> no VALID, BIN stays 6.
- Reset mid-filter: assert RST_N low during cnt=2 of a pending change -> all outputs 0, LOCKED=0; after release, held code reacquired with no UP/DOWN/ERR.
